// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, mid-bit sampling) feeding a first-word-fall-through FIFO.
// Sticky overrun/frame-error flags are reported alongside the FIFO count.
module uart_rx_fifo #(
   parameter int CLK_DIVIDER = 48,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_en,
   output logic [7:0] status,
   input  logic       err_clr
);

   localparam int TW = $clog2(CLK_DIVIDER + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [TW-1:0] T_HALF = TW'(CLK_DIVIDER / 2);
   localparam logic [TW-1:0] T_FULL = TW'(CLK_DIVIDER);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   localparam logic [4:0]    DEPTH  = 5'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            meta_q, rxs_q;
   logic            push_q, push_d;
   logic            fe_q, fe_d;
   logic            ovr_q, ovr_d;
   logic [PW-1:0]   wr_q, wr_d;
   logic [PW-1:0]   rd_q, rd_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic            tick, fe_set, pop, accept;

   // IDLE is only ever entered with rxs high, so a low level here is a fresh falling edge.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      push_d  = 1'b0;
      fe_set  = 1'b0;
      tick    = (timer_q == T_ONE);
      unique case (state_q)
         S_IDLE: begin
            if (!rxs_q) begin
               state_d = S_START;
               timer_d = T_HALF;
            end
         end
         S_START: begin
            if (!tick) begin
               timer_d = timer_q - 1'b1;
            end else if (rxs_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DATA;
               timer_d = T_FULL;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (!tick) begin
               timer_d = timer_q - 1'b1;
            end else begin
               shift_d = {rxs_q, shift_q[7:1]};
               timer_d = T_FULL;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (!tick) begin
               timer_d = timer_q - 1'b1;
            end else if (rxs_q) begin
               push_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               fe_set  = 1'b1;
               state_d = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (rxs_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A full FIFO still takes the byte when the head leaves in the same cycle.
   always_comb begin
      pop    = rd_en && (cnt_q != 5'd0);
      accept = push_q && ((cnt_q < DEPTH) || pop);
      wr_d   = accept ? wr_q + 1'b1 : wr_q;
      rd_d   = pop ? rd_q + 1'b1 : rd_q;
      cnt_d  = cnt_q;
      if (accept && !pop) begin
         cnt_d = cnt_q + 5'd1;
      end else if (!accept && pop) begin
         cnt_d = cnt_q - 5'd1;
      end
      ovr_d = ovr_q;
      if (push_q && !accept) begin
         ovr_d = 1'b1;
      end else if (err_clr) begin
         ovr_d = 1'b0;
      end
      fe_d = fe_q;
      if (fe_set) begin
         fe_d = 1'b1;
      end else if (err_clr) begin
         fe_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         meta_q  <= 1'b1;
         rxs_q   <= 1'b1;
         push_q  <= 1'b0;
         fe_q    <= 1'b0;
         ovr_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         meta_q  <= rxd;
         rxs_q   <= meta_q;
         push_q  <= push_d;
         fe_q    <= fe_d;
         ovr_q   <= ovr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_q] <= shift_q;
   end

   assign rd_valid = (cnt_q != 5'd0);
   assign rd_data  = rd_valid ? mem_q[rd_q] : 8'h00;
   assign status   = {ovr_q, fe_q, 1'b0, cnt_q};

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, checked against
// a queue-based model of the FIFO contents and sticky flags.
module tb_uart_rx_fifo;

   localparam int DIV   = 48;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset, rxd, rd_en, err_clr;
   logic [7:0] rd_data, status;
   logic       rd_valid;

   int passed = 0;
   int total  = 0;
   int lat    = 460;

   byte unsigned mq[$];
   bit m_ovr, m_fe;

   uart_rx_fifo #(.CLK_DIVIDER(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rxd(rxd),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_en(rd_en),
      .status(status), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] m_status();
      return {m_ovr, m_fe, 1'b0, 5'(mq.size())};
   endfunction

   function automatic logic [7:0] m_head();
      return (mq.size() > 0) ? mq[0] : 8'h00;
   endfunction

   function automatic void m_push(input logic [7:0] b);
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovr = 1'b1;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) @(negedge clk);
      end
      rxd = stop;
      repeat (DIV) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic do_pop();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rxd = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      mq.delete(); m_ovr = 0; m_fe = 0;
      @(negedge clk);
      total++;
      if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rd_valid);
      else passed++;
      total++;
      if (rd_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rd_data);
      else passed++;
      total++;
      if (status !== m_status()) $display("FAIL reset_status: got %h want %h", status, m_status());
      else passed++;
   endtask

   task automatic test_single();
      int rise = -1;
      logic [7:0] b;
      fork
         send_frame(8'h55, 1'b1);
         for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1 && rise < 0) rise = c;
         end
      join
      m_push(8'h55);
      total++;
      if (rise < 455 || rise > 461) $display("FAIL latency: got %0d want 455..461", rise);
      else passed++;
      if (rise > 0) lat = rise;
      total++;
      if (rd_data !== 8'h55) $display("FAIL single_data: got %h want 55", rd_data);
      else passed++;
      total++;
      if (status !== 8'h01) $display("FAIL single_status: got %h want 01", status);
      else passed++;
      do_pop(); void'(mq.pop_front());
      total++;
      if (rd_valid !== 1'b0 || status !== m_status())
         $display("FAIL single_pop: got %b/%h want 0/%h", rd_valid, status, m_status());
      else passed++;
      repeat (3) begin
         b = 8'($urandom);
         send_frame(b, 1'b1); m_push(b);
         @(negedge clk);
         total++;
         if (rd_data !== m_head() || status !== m_status())
            $display("FAIL rand_byte: got %h/%h want %h/%h", rd_data, status, m_head(), m_status());
         else passed++;
         do_pop(); void'(mq.pop_front());
      end
   endtask

   task automatic test_glitch();
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (100) @(negedge clk);
      total++;
      if (rd_valid !== 1'b0 || status !== m_status())
         $display("FAIL glitch: got %b/%h want 0/%h", rd_valid, status, m_status());
      else passed++;
      send_frame(8'hA3, 1'b1); m_push(8'hA3);
      repeat (4) @(negedge clk);
      total++;
      if (rd_data !== 8'hA3 || status !== 8'h01)
         $display("FAIL after_glitch: got %h/%h want a3/01", rd_data, status);
      else passed++;
      do_pop(); void'(mq.pop_front());
   endtask

   task automatic test_frame_err();
      send_frame(8'h0F, 1'b0);
      rxd = 1'b0;
      m_fe = 1'b1;
      repeat (500) @(negedge clk);
      total++;
      if (status !== m_status() || rd_valid !== 1'b0)
         $display("FAIL break_mid: got %h/%b want %h/0", status, rd_valid, m_status());
      else passed++;
      repeat (500) @(negedge clk);
      rxd = 1'b1;
      repeat (10) @(negedge clk);
      total++;
      if (status !== 8'h40 || rd_valid !== 1'b0)
         $display("FAIL frame_err: got %h/%b want 40/0", status, rd_valid);
      else passed++;
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      m_fe = 1'b0;
      total++;
      if (status !== m_status()) $display("FAIL fe_clear: got %h want %h", status, m_status());
      else passed++;
   endtask

   task automatic test_overrun();
      for (int b = 1; b <= 5; b++) begin
         send_frame(8'(b), 1'b1); m_push(8'(b));
         repeat (4) @(negedge clk);
      end
      total++;
      if (status !== 8'h84 || status !== m_status())
         $display("FAIL overrun_status: got %h want 84", status);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rd_data !== m_head()) $display("FAIL overrun_order%0d: got %h want %h", k, rd_data, m_head());
         else passed++;
         do_pop(); void'(mq.pop_front());
      end
      total++;
      if (status !== m_status()) $display("FAIL overrun_drained: got %h want %h", status, m_status());
      else passed++;
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      m_ovr = 1'b0;
      total++;
      if (status !== m_status()) $display("FAIL ovr_clear: got %h want %h", status, m_status());
      else passed++;
   endtask

   task automatic test_full_pop();
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1); m_push(b);
         repeat (4) @(negedge clk);
      end
      b = 8'($urandom);
      fork
         send_frame(b, 1'b1);
         begin
            repeat (lat - 1) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
         end
      join
      void'(mq.pop_front()); m_push(b);
      repeat (4) @(negedge clk);
      total++;
      if (status !== 8'h04 || status !== m_status())
         $display("FAIL full_pop_status: got %h want 04", status);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rd_data !== m_head()) $display("FAIL full_pop_order%0d: got %h want %h", k, rd_data, m_head());
         else passed++;
         do_pop(); void'(mq.pop_front());
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, 1'b1); m_push(b);
      repeat (4) @(negedge clk);
      b = 8'hF0 | 8'($urandom_range(0, 15));
      fork
         send_frame(b, 1'b1);
         begin
            repeat (5 * DIV + DIV / 2) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      join
      mq.delete(); m_ovr = 0; m_fe = 0;
      repeat (4) @(negedge clk);
      total++;
      if (status !== m_status() || rd_valid !== 1'b0 || rd_data !== 8'h00)
         $display("FAIL reset_mid: got %h/%b/%h want %h/0/00", status, rd_valid, rd_data, m_status());
      else passed++;
      send_frame(8'hC3, 1'b1); m_push(8'hC3);
      repeat (4) @(negedge clk);
      total++;
      if (rd_data !== 8'hC3 || status !== 8'h01)
         $display("FAIL after_reset: got %h/%h want c3/01", rd_data, status);
      else passed++;
      do_pop(); void'(mq.pop_front());
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       stop;
      int         n;
      repeat (16) begin
         b = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(b, stop);
         if (stop) m_push(b);
         else m_fe = 1'b1;
         repeat (4) @(negedge clk);
         total++;
         if (status !== m_status() || rd_data !== m_head())
            $display("FAIL random: got %h/%h want %h/%h", status, rd_data, m_status(), m_head());
         else passed++;
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) begin
            do_pop();
            if (mq.size() > 0) void'(mq.pop_front());
         end
         if ($urandom_range(0, 3) == 0) begin
            err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
            m_ovr = 1'b0; m_fe = 1'b0;
         end
      end
      total++;
      if (status !== m_status() || rd_data !== m_head())
         $display("FAIL random_end: got %h/%h want %h/%h", status, rd_data, m_status(), m_head());
      else passed++;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
